// File: rtl/flock_sprite_engine.sv
// Bird flock animator: on each frame tick it erases every live bird, advances positions,
// then redraws them, streaming one pixel per cycle into the display's plot port.
module flock_sprite_engine #(
  parameter int         NUM_BIRDS = 2,
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter int         SPEED     = 1,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            frame_tick,
  input  logic                                            spawn,
  input  logic [(NUM_BIRDS > 1 ? $clog2(NUM_BIRDS) : 1)-1:0] spawn_id,
  input  logic [X_W-1:0]                                  spawn_x,
  input  logic [Y_W-1:0]                                  spawn_y,
  input  logic                                            spawn_dir,
  input  logic                                            kill,
  input  logic [(NUM_BIRDS > 1 ? $clog2(NUM_BIRDS) : 1)-1:0] kill_id,
  output logic                                            ready,
  output logic [X_W-1:0]                                  x_out,
  output logic [Y_W-1:0]                                  y_out,
  output logic [2:0]                                      colour_out,
  output logic                                            plot,
  output logic                                            frame_done,
  output logic                                            overrun
);

  localparam int             ID_W     = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
  localparam logic [X_W:0]   SW_X     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SH_Y     = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0]   SPD_X    = (X_W+1)'(SPEED);
  localparam logic [X_W-1:0] X_MAX    = X_W'(SCREEN_W - 1);
  localparam logic [3:0]     LAST_PIX = 4'd9;

  typedef enum logic [2:0] {IDLE, ERASE, UPDATE, DRAW, DONE} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] slot_reg, slot_next;
  logic [3:0]      pix_reg, pix_next;
  logic            overrun_reg;

  logic [NUM_BIRDS-1:0] active_vec, dying_vec, flap_vec;
  logic [NUM_BIRDS-1:0] spawn_hit, kill_hit;
  logic [X_W-1:0]       x_arr [NUM_BIRDS];
  logic [Y_W-1:0]       y_arr [NUM_BIRDS];
  logic [X_W-1:0]       spawn_x_clamped;

  assign ready           = (state_reg == IDLE);
  assign frame_done      = (state_reg == DONE);
  assign overrun         = overrun_reg;
  assign spawn_x_clamped = ({1'b0, spawn_x} >= SW_X) ? X_MAX : spawn_x;

  // Per-slot bird state: spawn beats kill, and the UPDATE cycle moves or retires the bird.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BIRDS; gi++) begin : g_slot
      logic           active_reg, dying_reg, dir_reg, flap_reg;
      logic [X_W-1:0] x_reg, x_adv;
      logic [Y_W-1:0] y_reg;
      logic [X_W:0]   x_wide, x_sum;

      assign spawn_hit[gi]  = ready && spawn && (spawn_id == ID_W'(gi));
      assign kill_hit[gi]   = ready && kill && (kill_id == ID_W'(gi)) && active_reg && !spawn_hit[gi];
      assign active_vec[gi] = active_reg;
      assign dying_vec[gi]  = dying_reg;
      assign flap_vec[gi]   = flap_reg;
      assign x_arr[gi]      = x_reg;
      assign y_arr[gi]      = y_reg;
      assign x_wide         = {1'b0, x_reg};

      always_comb begin
        x_sum = x_wide + SPD_X;
        x_adv = '0;
        if (!dir_reg) begin
          x_adv = (x_sum >= SW_X) ? X_W'(x_sum - SW_X) : X_W'(x_sum);
        end else begin
          x_adv = (x_wide < SPD_X) ? X_W'(x_wide + SW_X - SPD_X) : X_W'(x_wide - SPD_X);
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          active_reg <= 1'b0;
          dying_reg  <= 1'b0;
          dir_reg    <= 1'b0;
          flap_reg   <= 1'b0;
          x_reg      <= '0;
          y_reg      <= '0;
        end else if (spawn_hit[gi]) begin
          active_reg <= 1'b1;
          dying_reg  <= 1'b0;
          dir_reg    <= spawn_dir;
          flap_reg   <= 1'b0;
          x_reg      <= spawn_x_clamped;
          y_reg      <= spawn_y;
        end else if (kill_hit[gi]) begin
          dying_reg <= 1'b1;
        end else if (state_reg == UPDATE && active_reg) begin
          if (dying_reg) begin
            active_reg <= 1'b0;
            dying_reg  <= 1'b0;
          end else begin
            x_reg    <= x_adv;
            flap_reg <= ~flap_reg;
          end
        end
      end
    end
  endgenerate

  // Lowest set slot index at or above lo; MSB of the result flags whether one exists.
  function automatic logic [ID_W:0] find_first(input logic [NUM_BIRDS-1:0] mask, input int lo);
    logic [ID_W:0] r;
    r = '0;
    for (int i = NUM_BIRDS - 1; i >= 0; i--) begin
      if (mask[i] && i >= lo) r = {1'b1, ID_W'(i)};
    end
    return r;
  endfunction

  logic [ID_W:0] first_tick, next_walk, first_draw;

  assign first_tick = find_first(active_vec | spawn_hit, 0);
  assign next_walk  = find_first(active_vec, int'(slot_reg) + 1);
  assign first_draw = find_first(active_vec & ~dying_vec, 0);

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    pix_next   = pix_reg;
    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          pix_next = '0;
          if (first_tick[ID_W]) begin
            state_next = ERASE;
            slot_next  = first_tick[ID_W-1:0];
          end else begin
            state_next = UPDATE;
          end
        end
      end
      ERASE, DRAW: begin
        if (pix_reg == LAST_PIX) begin
          pix_next = '0;
          if (next_walk[ID_W]) begin
            slot_next = next_walk[ID_W-1:0];
          end else begin
            state_next = (state_reg == ERASE) ? UPDATE : DONE;
          end
        end else begin
          pix_next = pix_reg + 4'd1;
        end
      end
      UPDATE: begin
        pix_next = '0;
        if (first_draw[ID_W]) begin
          state_next = DRAW;
          slot_next  = first_draw[ID_W-1:0];
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      slot_reg    <= '0;
      pix_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      pix_reg   <= pix_next;
      if (frame_tick && !ready) overrun_reg <= 1'b1;
    end
  end

  // Sprite offsets: body runs left from the anchor, head below it, wings fan out diagonally.
  logic           cur_flap;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;
  logic           x_ok, y_ok;
  int             dxi, dyi;

  assign cur_flap = flap_vec[slot_reg];
  assign cur_x    = x_arr[slot_reg];
  assign cur_y    = y_arr[slot_reg];

  always_comb begin
    dxi = 0;
    dyi = 0;
    case (pix_reg)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: dxi = -int'(pix_reg);
      4'd6: dyi = 1;
      4'd7, 4'd8, 4'd9: begin
        dxi = 4 - int'(pix_reg);
        dyi = cur_flap ? (int'(pix_reg) - 6) : (6 - int'(pix_reg));
      end
      default: ;
    endcase
  end

  assign px   = {1'b0, cur_x} + (X_W+1)'(dxi);
  assign py   = {1'b0, cur_y} + (Y_W+1)'(dyi);
  assign x_ok = !px[X_W] && (px < SW_X);
  assign y_ok = !py[Y_W] && (py < SH_Y);

  always_comb begin
    plot       = 1'b0;
    x_out      = '0;
    y_out      = '0;
    colour_out = BG_COLOUR;
    if (state_reg == ERASE || state_reg == DRAW) begin
      x_out      = px[X_W-1:0];
      y_out      = py[Y_W-1:0];
      colour_out = (state_reg == DRAW) ? FG_COLOUR : BG_COLOUR;
      plot       = x_ok && y_ok;
    end
  end

endmodule

// File: tb/tb_flock_sprite_engine.sv
// Directed bench for flock_sprite_engine: captures each frame's pixel stream and
// compares it against hand-computed sprite positions.
module tb_flock_sprite_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       spawn = 1'b0;
  logic [0:0] spawn_id = '0;
  logic [7:0] spawn_x = '0;
  logic [6:0] spawn_y = '0;
  logic       spawn_dir = 1'b0;
  logic       kill = 1'b0;
  logic [0:0] kill_id = '0;
  logic       ready, plot, frame_done, overrun;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  flock_sprite_engine dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .spawn(spawn), .spawn_id(spawn_id), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .spawn_dir(spawn_dir), .kill(kill), .kill_id(kill_id),
    .ready(ready), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [18:0] cap [0:127];
  int len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [18:0] exp_pix(input int ax, input int ay, input bit flap,
                                          input int p, input bit fg);
    int dxt[10] = '{0, -1, -2, -3, -4, -5, 0, -3, -4, -5};
    int dyt[10] = '{0, 0, 0, 0, 0, 0, 1, -1, -2, -3};
    int x, y, dy;
    bit pl;
    dy = dyt[p];
    if (flap && p >= 7) dy = -dy;
    x  = ax + dxt[p];
    y  = ay + dy;
    pl = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
    return {pl, (fg ? 3'b111 : 3'b000), x[7:0], y[6:0]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_spawn(input int id, input int x, input int y, input bit dir);
    spawn = 1'b1; spawn_id = id[0:0]; spawn_x = x[7:0]; spawn_y = y[6:0]; spawn_dir = dir;
    step();
    spawn = 1'b0;
  endtask

  task automatic do_kill(input int id);
    kill = 1'b1; kill_id = id[0:0];
    step();
    kill = 1'b0;
  endtask

  // Pulses frame_tick, records cycle n of the frame into cap[n]; optional mid-frame tick/spawn.
  task automatic run_frame(input int tick_at, input int spawn_at, output int flen);
    int cyc;
    flen = -1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      cap[cyc] = {plot, colour_out, x_out, y_out};
      if (frame_done) begin
        flen = cyc;
        break;
      end
      frame_tick = (cyc == tick_at);
      spawn      = (cyc == spawn_at);
      spawn_id = 1'b1; spawn_x = 8'd99; spawn_y = 7'd99;
      step();
      frame_tick = 1'b0;
      spawn      = 1'b0;
      cyc++;
    end
    step();
  endtask

  task automatic check_pass(input string tag, input int base, input int ax, input int ay,
                            input bit flap, input bit fg);
    for (int p = 0; p < 10; p++)
      check($sformatf("%s_p%0d", tag, p), 32'(cap[base + p]), 32'(exp_pix(ax, ay, flap, p, fg)));
  endtask

  initial begin
    int e_x[10] = '{10, 9, 8, 7, 6, 5, 10, 7, 6, 5};
    int e_y[10] = '{50, 50, 50, 50, 50, 50, 51, 49, 48, 47};
    int d_x[10] = '{11, 10, 9, 8, 7, 6, 11, 8, 7, 6};
    int d_y[10] = '{50, 50, 50, 50, 50, 50, 51, 51, 52, 53};
    int zeros;

    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_xy", {x_out, y_out}, 32'd0);
    check("rst_colour", 32'(colour_out), 32'd0);
    check("rst_done_ovr", {frame_done, overrun}, 32'd0);
    reset = 1'b0;
    step();

    // Single bird, one frame
    do_spawn(0, 10, 50, 0);
    run_frame(-1, -1, len);
    check("t1_len", len, 32'd22);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1_erase%0d", k), 32'(cap[1 + k]), {13'd0, 1'b1, 3'b000, e_x[k][7:0], e_y[k][6:0]});
      check($sformatf("t1_draw%0d", k), 32'(cap[12 + k]), {13'd0, 1'b1, 3'b111, d_x[k][7:0], d_y[k][6:0]});
    end
    check("t1_update_plot", 32'(cap[11][18]), 32'd0);

    // Horizontal wrap both directions
    do_reset();
    do_spawn(0, 159, 60, 0);
    do_spawn(1, 0, 60, 1);
    run_frame(-1, -1, len);
    check("t2_len", len, 32'd42);
    check("t2_negx", 32'(cap[12]), {13'd0, 1'b0, 3'b000, 8'hFF, 7'd60});
    check_pass("t2_e0", 1, 159, 60, 0, 0);
    check_pass("t2_e1", 11, 0, 60, 0, 0);
    check_pass("t2_d0", 22, 0, 60, 1, 1);
    check_pass("t2_d1", 32, 159, 60, 1, 1);

    // Top-edge clipping
    do_reset();
    do_spawn(0, 50, 1, 0);
    run_frame(-1, -1, len);
    check("t3_len", len, 32'd22);
    check_pass("t3_e", 1, 50, 1, 0, 0);
    check_pass("t3_d", 12, 51, 1, 1, 1);
    zeros = 0;
    for (int c = 1; c <= 21; c++) if (c != 11 && !cap[c][18]) zeros++;
    check("t3_clipped", zeros, 32'd2);

    // Kill: erased once, never redrawn; kill of an empty slot ignored
    do_kill(0);
    do_kill(1);
    run_frame(-1, -1, len);
    check("t4_len", len, 32'd12);
    check_pass("t4_e", 1, 51, 1, 1, 0);
    check("t4_noplot", {cap[11][18], cap[12][18]}, 32'd0);
    run_frame(-1, -1, len);
    check("t4_len2", len, 32'd2);
    check("t4_noplot2", 32'(cap[1][18]), 32'd0);

    // Overrun and spawn-while-busy
    do_reset();
    check("t5_ovr0", 32'(overrun), 32'd0);
    do_spawn(0, 20, 30, 0);
    run_frame(15, 3, len);
    check("t5_len", len, 32'd22);
    check("t5_ovr1", 32'(overrun), 32'd1);
    check_pass("t5_d", 12, 21, 30, 1, 1);
    run_frame(-1, -1, len);
    check("t5_len2", len, 32'd22);
    check("t5_ovr_sticky", 32'(overrun), 32'd1);
    check_pass("t5_d2", 12, 22, 30, 0, 1);

    // Spawn x clamp
    do_spawn(1, 200, 20, 0);
    run_frame(-1, -1, len);
    check("t7_len", len, 32'd42);
    check("t7_clamp", 32'(cap[11]), {13'd0, 1'b1, 3'b000, 8'd159, 7'd20});

    // Reset in the middle of ERASE
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("t6_pre_plot", 32'(plot), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_plot", 32'(plot), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_ovr", 32'(overrun), 32'd0);
    check("t6_xy", {x_out, y_out}, 32'd0);
    step();
    reset = 1'b0;
    run_frame(-1, -1, len);
    check("t6_len", len, 32'd2);
    check("t6_noplot", 32'(cap[1][18]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
